// File: rtl/rr_arbiter_mux.sv
// N-port round-robin arbiter with payload mux and a registered valid/ready output stage.
// Optional packet lock (hold the grant until a last beat) is enabled by RR_ARBITER_MUX_PKT_LOCK_EN.
module rr_arbiter_mux #(
  parameter  int unsigned PORTS_N = 3,
  parameter  int unsigned DATA_W  = 32,
  localparam int unsigned PORTS_W = (PORTS_N > 1) ? $clog2(PORTS_N) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [PORTS_N-1:0]          i_master_valid,
  output logic [PORTS_N-1:0]          o_master_ready,
  input  logic [PORTS_N*DATA_W-1:0]   i_master_data,
  input  logic [PORTS_N-1:0]          i_master_last,
  output logic                        o_slave_valid,
  input  logic                        i_slave_ready,
  output logic [DATA_W-1:0]           o_slave_data,
  output logic                        o_slave_last,
  output logic [PORTS_W-1:0]          o_slave_id
);

  // One extra bit so r_ptr + offset never overflows before the modulo fold.
  localparam int unsigned IDX_W = PORTS_W + 1;

  logic [PORTS_W-1:0] r_ptr;
  logic [PORTS_N-1:0] w_req;
  logic               w_load;
  logic               w_any;
  logic               w_xfer;
  logic               w_found;
  logic [IDX_W-1:0]   w_idx;
  logic [PORTS_W-1:0] w_cand;
  logic [PORTS_W-1:0] w_grant;
  logic [IDX_W-1:0]   w_inc;
  logic [PORTS_W-1:0] w_ptr_next;
  logic [PORTS_W-1:0] w_ptr_upd;
  logic [DATA_W-1:0]  w_data;
  logic               w_last;

  assign w_load = ~o_slave_valid | i_slave_ready;

`ifdef RR_ARBITER_MUX_PKT_LOCK_EN
  logic               r_lock;
  logic [PORTS_W-1:0] r_lock_id;

  // While a packet is open only the owning port may request.
  always_comb begin
    w_req = i_master_valid;
    if (r_lock) begin
      w_req = '0;
      for (int unsigned p = 0; p < PORTS_N; p++) begin
        if (r_lock_id == PORTS_W'(p)) begin
          w_req[p] = i_master_valid[p];
        end
      end
    end
  end

  // A non-last beat keeps priority on the same port; the last beat releases it.
  assign w_ptr_upd = w_last ? w_ptr_next : w_grant;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lock    <= 1'b0;
      r_lock_id <= '0;
    end else if (w_xfer) begin
      r_lock    <= ~w_last;
      r_lock_id <= w_grant;
    end
  end
`else
  assign w_req     = i_master_valid;
  assign w_ptr_upd = w_ptr_next;
`endif

  assign w_any  = |w_req;
  assign w_xfer = w_load & w_any;

  // Rotating search starting at r_ptr, folded modulo PORTS_N.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < PORTS_N; i++) begin
      w_idx = IDX_W'(r_ptr) + IDX_W'(i);
      if (w_idx >= IDX_W'(PORTS_N)) begin
        w_idx = w_idx - IDX_W'(PORTS_N);
      end
      w_cand = PORTS_W'(w_idx);
      if (!w_found && w_req[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  // Pointer moves one past the granted port, wrapping for non-power-of-2 counts.
  always_comb begin
    w_inc      = IDX_W'(w_grant) + IDX_W'(1);
    w_ptr_next = PORTS_W'(w_inc);
    if (w_inc == IDX_W'(PORTS_N)) begin
      w_ptr_next = '0;
    end
  end

  always_comb begin
    o_master_ready = '0;
    for (int unsigned p = 0; p < PORTS_N; p++) begin
      if (w_xfer && (w_grant == PORTS_W'(p))) begin
        o_master_ready[p] = 1'b1;
      end
    end
  end

  // Payload mux for the granted port.
  always_comb begin
    w_data = '0;
    w_last = 1'b0;
    for (int unsigned p = 0; p < PORTS_N; p++) begin
      if (w_grant == PORTS_W'(p)) begin
        w_data = i_master_data[p*DATA_W +: DATA_W];
        w_last = i_master_last[p];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr         <= '0;
      o_slave_valid <= 1'b0;
      o_slave_data  <= '0;
      o_slave_last  <= 1'b0;
      o_slave_id    <= '0;
    end else begin
      if (w_load) begin
        o_slave_valid <= w_xfer;
        if (w_xfer) begin
          o_slave_data <= w_data;
          o_slave_last <= w_last;
          o_slave_id   <= w_grant;
        end
      end
      if (w_xfer) begin
        r_ptr <= w_ptr_upd;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Directed bench for rr_arbiter_mux with a scoreboard of expected output beats.
module tb_rr_arbiter_mux;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 2;
`ifdef RR_ARBITER_MUX_PKT_LOCK_EN
  localparam logic [N-1:0] LAST_DEF = 3'b111;
`else
  localparam logic [N-1:0] LAST_DEF = 3'b101;
`endif

  typedef struct packed {
    logic [PW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    mvalid;
  logic [N-1:0]    mready;
  logic [N*DW-1:0] mdata;
  logic [N-1:0]    mlast;
  logic            svalid;
  logic            sready;
  logic [DW-1:0]   sdata;
  logic            slast;
  logic [PW-1:0]   sid;

  beat_t       sb[$];
  int unsigned d_hist[$];
  int unsigned exp_ids[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_ptr;
  bit          m_valid;
  bit          m_lock;
  int          m_lock_id;

  rr_arbiter_mux #(.PORTS_N(N), .DATA_W(DW)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_master_valid (mvalid),
    .o_master_ready (mready),
    .i_master_data  (mdata),
    .i_master_last  (mlast),
    .o_slave_valid  (svalid),
    .i_slave_ready  (sready),
    .o_slave_data   (sdata),
    .o_slave_last   (slast),
    .o_slave_id     (sid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) begin
      int idx;
      idx = (m_ptr + i) % int'(N);
      if (m_lock && idx != m_lock_id) continue;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr     = 0;
    m_valid   = 1'b0;
    m_lock    = 1'b0;
    m_lock_id = 0;
    sb.delete();
  endtask

  // One clock: check ready and any consumed beat, predict, then check output valid.
  task automatic cycle();
    int           g;
    bit           load;
    bit           xfer;
    logic [N-1:0] exp_rdy;
    beat_t        b;
    #1;
    g       = model_grant(mvalid);
    load    = !m_valid || sready;
    xfer    = load && (g >= 0);
    exp_rdy = xfer ? (N'(1) << g) : '0;
    chk("master_ready", 64'(mready), 64'(exp_rdy));
    if (m_valid && sready) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL sb_empty: observed beat id %0d expected none", sid);
      end
      if (sb.size() != 0) begin
        b = sb.pop_front();
        chk("slave_data", 64'(sdata), 64'(b.data));
        chk("slave_id", 64'(sid), 64'(b.id));
        chk("slave_last", 64'(slast), 64'(b.last));
        d_hist.push_back(int'(sid));
      end
    end
    if (xfer) begin
      b.id   = PW'(g);
      b.data = mdata[g*DW +: DW];
      b.last = mlast[g];
      sb.push_back(b);
`ifdef RR_ARBITER_MUX_PKT_LOCK_EN
      if (!mlast[g]) begin
        m_lock    = 1'b1;
        m_lock_id = g;
        m_ptr     = g;
      end else begin
        m_lock = 1'b0;
        m_ptr  = (g + 1) % int'(N);
      end
`else
      m_ptr = (g + 1) % int'(N);
`endif
    end
    if (load) m_valid = xfer;
    @(posedge clk);
    @(negedge clk);
    chk("slave_valid", 64'(svalid), 64'(m_valid));
  endtask

  task automatic drain();
    mvalid = '0;
    cycle();
  endtask

  task automatic check_hist(input string tag, input int unsigned e[$]);
    chk($sformatf("%s_len", tag), 64'(d_hist.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < d_hist.size(); i++) begin
      chk($sformatf("%s_id%0d", tag, i), 64'(d_hist[i]), 64'(e[i]));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    mvalid = '0;
    mlast  = LAST_DEF;
    mdata  = {32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
    sready = 1'b1;
    model_reset();
    #2;
    chk("rst_valid", 64'(svalid), 64'd0);
    chk("rst_ready", 64'(mready), 64'd0);
    chk("rst_id", 64'(sid), 64'd0);
    chk("rst_data", 64'(sdata), 64'd0);
    chk("rst_last", 64'(slast), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All ports valid: strict rotation.
    d_hist.delete();
    mvalid = 3'b111;
    repeat (7) cycle();
    drain();
    exp_ids = '{0, 1, 2, 0, 1, 2, 0};
    check_hist("rr_all", exp_ids);

    // Only port 2 requests, then everyone: pointer must wrap to 0.
    d_hist.delete();
    mvalid = 3'b100;
    repeat (4) cycle();
    mvalid = 3'b111;
    cycle();
    drain();
    exp_ids = '{2, 2, 2, 2, 0};
    check_hist("single_p2", exp_ids);

    // Downstream stall for three cycles with a beat held.
    d_hist.delete();
    mvalid = 3'b111;
    cycle();
    sready = 1'b0;
    repeat (3) begin
      cycle();
      chk("stall_ready", 64'(mready), 64'd0);
      chk("stall_data", 64'(sdata), 64'h0000_00B1);
      chk("stall_id", 64'(sid), 64'd1);
      chk("stall_last", 64'(slast), 64'(LAST_DEF[1]));
    end
    sready = 1'b1;
    cycle();
    drain();
    exp_ids = '{1, 2};
    check_hist("stall", exp_ids);

    // Asynchronous reset with a beat in the output register.
    mvalid = 3'b111;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(svalid), 64'd0);
    chk("async_rst_data", 64'(sdata), 64'd0);
    model_reset();
    mvalid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d_hist.delete();
    mvalid = 3'b111;
    cycle();
    drain();
    exp_ids = '{0};
    check_hist("post_rst", exp_ids);

`ifdef RR_ARBITER_MUX_PKT_LOCK_EN
    // Port 1 three-beat packet with a one-cycle valid gap.
    d_hist.delete();
    mvalid = 3'b111;
    mlast  = 3'b101;
    mdata[DW +: DW] = 32'h0000_0011;
    cycle();
    mdata[DW +: DW] = 32'h0000_0012;
    cycle();
    mvalid = 3'b101;
    cycle();
    chk("gap_ready", 64'(mready), 64'd0);
    mvalid = 3'b111;
    mlast  = 3'b111;
    mdata[DW +: DW] = 32'h0000_0013;
    cycle();
    mdata[DW +: DW] = 32'h0000_00B1;
    cycle();
    drain();
    exp_ids = '{1, 1, 1, 2};
    check_hist("pkt_lock", exp_ids);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_mux.md
Name: rr_arbiter_mux

Overview:
- N-port round-robin arbiter with payload mux and a registered output stage.
- Generalises the earlier valid-only round-robin: carries a data/last payload and returns a per-port ready.
- Rotates priority past each granted port.
- Sits between N request streams and a single downstream valid/ready consumer.
- Sustains one transfer per cycle.

Parameters:
PORTS_N, 3, number of master ports (>=2)
DATA_W, 32, payload width per port
PORTS_W, max(1,$clog2(PORTS_N)), derived localparam, width of port index

Ports:
i_clk  input  1  clock, rising edge
i_reset_n  input  1  reset, asynchronous, active-low
i_master_valid  input  PORTS_N  per-port request valid
o_master_ready  output  PORTS_N  per-port accept; at most one bit high
i_master_data  input  PORTS_N*DATA_W  port p payload at [p*DATA_W +: DATA_W]
i_master_last  input  PORTS_N  per-port end-of-packet flag
o_slave_valid  output  1  registered output valid
i_slave_ready  input  1  downstream accept
o_slave_data  output  DATA_W  registered payload
o_slave_last  output  1  registered last flag of the selected beat
o_slave_id  output  PORTS_W  index of the port that supplied the beat

Behaviour:
- Reset values (async, i_reset_n low):
  - o_slave_valid=0, o_slave_data=0, o_slave_last=0, o_slave_id=0.
  - Internal pointer r_ptr=0; lock state idle.
  - o_master_ready is combinational and is therefore 0 while the output register is full and stalled.
- Output register load enable: w_load = !o_slave_valid | i_slave_ready.
- Arbitration (combinational):
  - Search i_master_valid starting at index r_ptr, then r_ptr+1, ... wrapping modulo PORTS_N.
  - The first valid port found is grant g.
  - w_any = |i_master_valid.
- Ready:
  - o_master_ready[g] = w_load & w_any.
  - All other ready bits are 0.
  - Ready depends on valid; masters must not wait on ready before asserting valid.
- Master transfer: o_master_valid[g] & o_master_ready[g]. On a master transfer, next cycle:
  - o_slave_valid=1
  - o_slave_data=data[g]
  - o_slave_last=last[g]
  - o_slave_id=g
- No master transfer and w_load=1: o_slave_valid<=0. Data, last and id hold their previous values.
- w_load=0 (stall): all output registers hold. Downstream sees stable data while valid & !ready.
- Latency: 1 cycle from master transfer to o_slave_valid. Throughput: 1 beat/cycle when i_slave_ready is held high.
- Pointer update on a master transfer from g: r_ptr <= (g+1) mod PORTS_N. The wrap from PORTS_N-1 to 0 must be correct for non-power-of-2 PORTS_N.
- Pointer hold: no master transfer means r_ptr holds.
- Fairness: with all ports continuously valid, grants cycle 0,1,...,N-1,0,...
- Single requester: with only port k valid, k is granted every cycle regardless of r_ptr.
- Reset mid-operation: all state clears immediately; any beat in the output register is dropped.

Optional Feature:
Macro RR_ARBITER_MUX_PKT_LOCK_EN.
- Defined: packet lock.
  - On a master transfer from g with last[g]=0: set lock, record r_lock_id=g, keep r_ptr=g.
  - While locked, only port r_lock_id may be granted. If that port is not valid, o_master_ready is all-zero, even when other ports are valid.
  - A transfer from the locked port with last=1 clears lock and sets r_ptr=(g+1) mod PORTS_N.
  - Reset clears lock.
- Undefined: no lock logic. i_master_last is only carried through to o_slave_last; arbitration is per beat.

Test Plan:
- Reset, PORTS_N=3, all valid=0, i_slave_ready=1 -> o_slave_valid=0, o_master_ready=3'b000, o_slave_id=0.
- All 3 ports valid continuously, distinct data 0xA0/0xB1/0xC2, i_slave_ready=1 -> o_slave_id sequence 0,1,2,0,1,2 on consecutive cycles, data matches.
- Only port 2 valid for 4 cycles -> four beats with id=2; next grant with all valid is port 0 (pointer wrapped).
- Beat loaded, then i_slave_ready=0 for 3 cycles with all ports valid -> o_slave_data/id stable, o_master_ready=0 throughout; first cycle ready=1 resumes with the next RR port.
- Assert i_reset_n=0 while o_slave_valid=1 -> o_slave_valid=0 asynchronously; after release the first grant is port 0.
- With RR_ARBITER_MUX_PKT_LOCK_EN: port 1 sends a 3-beat packet (last on beat 3) while ports 0 and 2 stay valid, with a 1-cycle gap in port 1 valid -> ids 1,1,1 only, ready all-zero during the gap; next grant is port 2.
